// File: rtl/div_issue_ctrl.sv
//------------------------------------------------------------------------------
// div_issue_ctrl: issue/writeback wrapper around the serial divider; W-operand
// extension, single in-flight tracking, multiplier/divider writeback merge.
//------------------------------------------------------------------------------
`default_nettype none

module div_issue_ctrl #(
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     fu_valid_i,
  output logic                     div_ready_o,
  input  logic [1:0]               op_i,
  input  logic                     word_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic [XLEN-1:0]          div_op_a_o,
  output logic [XLEN-1:0]          div_op_b_o,
  output logic [1:0]               div_opcode_o,
  output logic [TRANS_ID_BITS-1:0] div_id_o,
  output logic                     div_in_vld_o,
  input  logic                     div_in_rdy_i,
  input  logic                     div_out_vld_i,
  output logic                     div_out_rdy_o,
  input  logic [TRANS_ID_BITS-1:0] div_id_i,
  input  logic [XLEN-1:0]          div_res_i,
  input  logic                     mul_valid_i,
  input  logic [XLEN-1:0]          mul_result_i,
  input  logic [TRANS_ID_BITS-1:0] mul_trans_id_i,
  output logic                     valid_o,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [XLEN-1:0]          op_a_q, op_b_q;
  logic [1:0]               opcode_q;
  logic [TRANS_ID_BITS-1:0] id_q;
  logic                     word_q;

  logic                     accept;
  logic                     div_wb;
  logic [XLEN-1:0]          op_a_ext, op_b_ext;

  function automatic logic [XLEN-1:0] extend32(input logic [XLEN-1:0] v, input logic sgn);
    return {{(XLEN-32){sgn & v[31]}}, v[31:0]};
  endfunction

  // Ready is gated by rst_i so issue never sees a slot while reset is held.
  assign div_ready_o = (state_q == IDLE) & ~flush_i & ~rst_i;
  assign accept      = fu_valid_i & div_ready_o;

  assign op_a_ext = word_i ? extend32(operand_a_i, op_i[0]) : operand_a_i;
  assign op_b_ext = word_i ? extend32(operand_b_i, op_i[0]) : operand_b_i;

  assign div_in_vld_o  = (state_q == ISSUE) & ~flush_i;
  assign div_out_rdy_o = (state_q == BUSY) & ~mul_valid_i;
  assign div_wb        = (state_q == BUSY) & div_out_vld_i & ~flush_i;

  assign div_op_a_o   = op_a_q;
  assign div_op_b_o   = op_b_q;
  assign div_opcode_o = opcode_q;
  assign div_id_o     = id_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   if (div_in_rdy_i) state_d = BUSY;
      BUSY:    if (div_out_vld_i & ~mul_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      opcode_q <= '0;
      id_q     <= '0;
      word_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flush_i) begin
        word_q <= 1'b0;
      end else if (accept) begin
        op_a_q   <= op_a_ext;
        op_b_q   <= op_b_ext;
        opcode_q <= op_i;
        id_q     <= trans_id_i;
        word_q   <= word_i;
      end
    end
  end

  // W results are sign-extended from bit 31 even for unsigned W ops.
  always_comb begin
    valid_o    = 1'b0;
    result_o   = '0;
    trans_id_o = '0;
    if (mul_valid_i) begin
      valid_o    = 1'b1;
      result_o   = mul_result_i;
      trans_id_o = mul_trans_id_i;
    end else if (div_wb) begin
      valid_o    = 1'b1;
      result_o   = word_q ? extend32(div_res_i, 1'b1) : div_res_i;
      trans_id_o = div_id_i;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: directed scenarios plus randomized ops
// checked against a RISC-V divide reference model; the bench also plays the divider.
`default_nettype none

module tb_div_issue_ctrl;
  localparam int XLEN = 64;
  localparam int TIDW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush_i;
  logic            fu_valid_i;
  logic            div_ready_o;
  logic [1:0]      op_i;
  logic            word_i;
  logic [XLEN-1:0] operand_a_i, operand_b_i;
  logic [TIDW-1:0] trans_id_i;
  logic [XLEN-1:0] div_op_a_o, div_op_b_o;
  logic [1:0]      div_opcode_o;
  logic [TIDW-1:0] div_id_o;
  logic            div_in_vld_o;
  logic            div_in_rdy_i;
  logic            div_out_vld_i;
  logic            div_out_rdy_o;
  logic [TIDW-1:0] div_id_i;
  logic [XLEN-1:0] div_res_i;
  logic            mul_valid_i;
  logic [XLEN-1:0] mul_result_i;
  logic [TIDW-1:0] mul_trans_id_i;
  logic            valid_o;
  logic [XLEN-1:0] result_o;
  logic [TIDW-1:0] trans_id_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.XLEN(XLEN), .TRANS_ID_BITS(TIDW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_i), .fu_valid_i(fu_valid_i),
    .div_ready_o(div_ready_o), .op_i(op_i), .word_i(word_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .trans_id_i(trans_id_i),
    .div_op_a_o(div_op_a_o), .div_op_b_o(div_op_b_o), .div_opcode_o(div_opcode_o),
    .div_id_o(div_id_o), .div_in_vld_o(div_in_vld_o), .div_in_rdy_i(div_in_rdy_i),
    .div_out_vld_i(div_out_vld_i), .div_out_rdy_o(div_out_rdy_o), .div_id_i(div_id_i),
    .div_res_i(div_res_i), .mul_valid_i(mul_valid_i), .mul_result_i(mul_result_i),
    .mul_trans_id_i(mul_trans_id_i), .valid_o(valid_o), .result_o(result_o),
    .trans_id_o(trans_id_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic settle(); #1; endtask
  task automatic tick();   @(posedge clk); #2; endtask

  // RISC-V 64-bit divide semantics, used by the behavioural divider.
  function automatic logic [63:0] rv_div64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    case (op)
      2'd0:    return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
      2'd1:    return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : (ovf ? a : 64'(sa / sb));
      2'd2:    return (b == 0) ? a : a % b;
      default: return (b == 0) ? a : (ovf ? 64'd0 : 64'(sa % sb));
    endcase
  endfunction

  // RISC-V W-op semantics computed on 32-bit values.
  function automatic logic [31:0] rv_div32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'd0:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd1:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      2'd2:    return (b == 0) ? a : a % b;
      default: return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
    endcase
  endfunction

  function automatic logic [63:0] rv_ref(input logic [1:0] op, input logic word, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] r;
    if (!word) return rv_div64(op, a, b);
    r = rv_div32(op, a[31:0], b[31:0]);
    return {{32{r[31]}}, r};
  endfunction

  function automatic logic [63:0] exp_ext(input logic [1:0] op, input logic word, input logic [63:0] v);
    if (!word) return v;
    if (op[0]) return {{32{v[31]}}, v[31:0]};
    return {32'h0, v[31:0]};
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 4))
      0:       return {$urandom, $urandom};
      1:       return 64'($urandom_range(0, 40));
      2:       return 64'h8000_0000_0000_0000;
      3:       return {$urandom, 32'h8000_0000};
      default: return 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 9));
    endcase
  endfunction

  task automatic wb_check(input string tag, input bit div_exp, input logic [63:0] res, input logic [TIDW-1:0] id);
    if (mul_valid_i) begin
      chk({tag, "_mul_vld"}, valid_o, 1);
      chk({tag, "_mul_res"}, result_o, mul_result_i);
      chk({tag, "_mul_id"}, trans_id_o, mul_trans_id_i);
    end else if (div_exp) begin
      chk({tag, "_div_vld"}, valid_o, 1);
      chk({tag, "_div_res"}, result_o, res);
      chk({tag, "_div_id"}, trans_id_o, id);
    end else begin
      chk({tag, "_no_vld"}, valid_o, 0);
      chk({tag, "_no_res"}, result_o, 0);
      chk({tag, "_no_id"}, trans_id_o, 0);
    end
  endtask

  // One complete divide: accept, hold in ISSUE, wait in BUSY, complete with
  // ncol multiplier collisions; ends in the idle cycle after writeback.
  task automatic run_op(input logic [1:0] op, input logic word, input logic [63:0] a,
                        input logic [63:0] b, input logic [TIDW-1:0] id, input int hold,
                        input int lat, input int ncol, input bit rnd_mul,
                        input logic [63:0] mdata, input logic [TIDW-1:0] mid);
    logic [63:0]     ea, eb, eres, dres;
    logic [TIDW-1:0] did;
    ea   = exp_ext(op, word, a);
    eb   = exp_ext(op, word, b);
    eres = rv_ref(op, word, a, b);
    dres = '0;
    did  = '0;
    fu_valid_i = 1; op_i = op; word_i = word; operand_a_i = a; operand_b_i = b;
    trans_id_i = id; mul_valid_i = 0; div_in_rdy_i = 0; div_out_vld_i = 0;
    settle();
    chk("accept_ready", div_ready_o, 1);
    chk("accept_in_vld", div_in_vld_o, 0);
    chk("accept_out_rdy", div_out_rdy_o, 0);
    tick();
    for (int i = 0; i <= hold; i++) begin
      fu_valid_i = 1; operand_a_i = {$urandom, $urandom}; operand_b_i = {$urandom, $urandom};
      trans_id_i = TIDW'($urandom); op_i = 2'($urandom); word_i = 1'($urandom);
      div_in_rdy_i = (i == hold);
      mul_valid_i = rnd_mul ? 1'($urandom) : 1'b0;
      mul_result_i = {$urandom, $urandom}; mul_trans_id_i = TIDW'($urandom);
      settle();
      chk("issue_in_vld", div_in_vld_o, 1);
      chk("issue_ready", div_ready_o, 0);
      chk("issue_out_rdy", div_out_rdy_o, 0);
      chk("issue_op_a", div_op_a_o, ea);
      chk("issue_op_b", div_op_b_o, eb);
      chk("issue_opcode", div_opcode_o, op);
      chk("issue_id", div_id_o, id);
      wb_check("issue", 0, 0, 0);
      if (i == hold) begin
        dres = rv_div64(div_opcode_o, div_op_a_o, div_op_b_o);
        did  = div_id_o;
      end
      tick();
    end
    for (int i = 0; i < lat; i++) begin
      div_in_rdy_i = 1'($urandom); div_out_vld_i = 0;
      mul_valid_i = rnd_mul ? 1'($urandom) : 1'b0;
      mul_result_i = {$urandom, $urandom}; mul_trans_id_i = TIDW'($urandom);
      settle();
      chk("busy_in_vld", div_in_vld_o, 0);
      chk("busy_ready", div_ready_o, 0);
      chk("busy_out_rdy", div_out_rdy_o, 64'(!mul_valid_i));
      wb_check("busy", 0, 0, 0);
      tick();
    end
    for (int i = 0; i <= ncol; i++) begin
      div_in_rdy_i = 0; div_out_vld_i = 1; div_res_i = dres; div_id_i = did;
      mul_valid_i = (i < ncol);
      mul_result_i = (i == 0) ? mdata : {$urandom, $urandom};
      mul_trans_id_i = (i == 0) ? mid : TIDW'($urandom);
      settle();
      chk("done_out_rdy", div_out_rdy_o, 64'(i == ncol));
      chk("done_ready", div_ready_o, 0);
      wb_check("done", 1, eres, id);
      tick();
    end
    div_out_vld_i = 0; fu_valid_i = 0; mul_valid_i = 0; div_in_rdy_i = 0;
    settle();
    chk("after_ready", div_ready_o, 1);
    chk("after_in_vld", div_in_vld_o, 0);
    chk("after_valid", valid_o, 0);
  endtask

  initial begin
    rst = 1; flush_i = 0; fu_valid_i = 0; op_i = 0; word_i = 0; operand_a_i = 0;
    operand_b_i = 0; trans_id_i = 0; div_in_rdy_i = 0; div_out_vld_i = 0; div_id_i = 0;
    div_res_i = 0; mul_valid_i = 0; mul_result_i = 0; mul_trans_id_i = 0;
    tick(); tick();
    fu_valid_i = 1;
    settle();
    chk("rst_ready", div_ready_o, 0);
    chk("rst_in_vld", div_in_vld_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_op_a", div_op_a_o, 0);
    chk("rst_id", div_id_o, 0);
    fu_valid_i = 0;
    rst = 0;
    settle();
    chk("post_rst_ready", div_ready_o, 1);

    // DIVW -7/2, DIVUW all-ones/1, collision, back-to-back REM
    run_op(2'd1, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 3'd4, 0, 2, 0, 0, 0, 0);
    run_op(2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd1, 1, 1, 0, 0, 0, 0);
    run_op(2'd1, 1'b0, 64'd1000, 64'd10, 3'd2, 0, 1, 1, 0, 64'h1234, 3'd5);
    run_op(2'd3, 1'b0, -64'sd100, 64'd7, 3'd6, 0, 3, 0, 0, 0, 0);
    run_op(2'd3, 1'b0, 64'd12345, 64'd0, 3'd7, 2, 0, 0, 0, 0, 0);

    // Flush in BUSY with divider completing in the same cycle
    fu_valid_i = 1; op_i = 2'd1; word_i = 0; operand_a_i = 64'd55; operand_b_i = 64'd5; trans_id_i = 3'd3;
    tick();
    fu_valid_i = 0; div_in_rdy_i = 1;
    tick();
    div_in_rdy_i = 0; flush_i = 1; fu_valid_i = 1; div_out_vld_i = 1; div_res_i = 64'd11; div_id_i = 3'd3;
    settle();
    chk("flush_busy_valid", valid_o, 0);
    chk("flush_busy_ready", div_ready_o, 0);
    tick();
    flush_i = 0; fu_valid_i = 0; div_out_vld_i = 0;
    settle();
    chk("flush_busy_after_ready", div_ready_o, 1);
    chk("flush_busy_after_valid", valid_o, 0);
    run_op(2'd1, 1'b0, 64'd100, 64'd7, 3'd0, 0, 1, 0, 0, 0, 0);

    // Flush in ISSUE forces in_vld low; flush in IDLE blocks accept
    fu_valid_i = 1; op_i = 2'd0; word_i = 1; operand_a_i = 64'd9; operand_b_i = 64'd3; trans_id_i = 3'd2;
    tick();
    fu_valid_i = 0; flush_i = 1;
    settle();
    chk("flush_issue_in_vld", div_in_vld_o, 0);
    tick();
    fu_valid_i = 1;
    settle();
    chk("flush_idle_ready", div_ready_o, 0);
    tick();
    flush_i = 0; fu_valid_i = 0;
    settle();
    chk("flush_idle_no_accept", div_in_vld_o, 0);
    chk("flush_idle_ready_back", div_ready_o, 1);

    // Reset during ISSUE
    fu_valid_i = 1; op_i = 2'd1; word_i = 0; operand_a_i = 64'd8; operand_b_i = 64'd2; trans_id_i = 3'd1;
    tick();
    fu_valid_i = 0;
    settle();
    chk("pre_rst_in_vld", div_in_vld_o, 1);
    rst = 1;
    settle();
    chk("async_rst_in_vld", div_in_vld_o, 0);
    chk("async_rst_ready", div_ready_o, 0);
    tick();
    rst = 0;
    settle();
    chk("rst_release_ready", div_ready_o, 1);
    chk("rst_release_in_vld", div_in_vld_o, 0);

    // Randomized ops with random hold, latency, collisions and mul traffic
    for (int n = 0; n < 60; n++) begin
      run_op(2'($urandom), 1'($urandom), rnd64(), rnd64(), TIDW'($urandom),
             $urandom_range(0, 2), $urandom_range(0, 4), $urandom_range(0, 2), 1'b1,
             {$urandom, $urandom}, TIDW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
Front/back-end stage wrapped around the serial divider in the multiply/divide functional unit.
- Upstream: accepts one div/rem operation from issue and, for W-variants, sign- or zero-extends the 32-bit operands.
- Divider side: presents the operation with the divider's one-cycle rdy->vld handshake, then tracks the single in-flight operation.
- Downstream: sign-extends W results and merges divider completions with the fixed-latency multiplier result onto one writeback port.

Parameters:
XLEN, 64, datapath width of operands and results.
TRANS_ID_BITS, 3, width of scoreboard transaction id.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous active-high reset.
flush_i  in  1  kill all in-flight divide state.
fu_valid_i  in  1  issue presents a divide op.
div_ready_o  out  1  block can accept an op this cycle.
op_i  in  2  0 udiv, 1 div, 2 urem, 3 rem.
word_i  in  1  1 = W-variant (32-bit) op.
operand_a_i  in  XLEN  dividend.
operand_b_i  in  XLEN  divisor.
trans_id_i  in  TRANS_ID_BITS  transaction id.
div_op_a_o  out  XLEN  registered dividend to divider.
div_op_b_o  out  XLEN  registered divisor to divider.
div_opcode_o  out  2  registered op_i.
div_id_o  out  TRANS_ID_BITS  registered trans id.
div_in_vld_o  out  1  divider input valid.
div_in_rdy_i  in  1  divider input ready.
div_out_vld_i  in  1  divider result valid.
div_out_rdy_o  out  1  divider result accept.
div_id_i  in  TRANS_ID_BITS  divider result id.
div_res_i  in  XLEN  divider result.
mul_valid_i  in  1  multiplier result valid; cannot stall.
mul_result_i  in  XLEN  multiplier result.
mul_trans_id_i  in  TRANS_ID_BITS  multiplier id.
valid_o  out  1  writeback valid.
result_o  out  XLEN  writeback data.
trans_id_o  out  TRANS_ID_BITS  writeback id.

Behaviour:
- FSM states: IDLE, ISSUE, BUSY. Reset (async, rst_i=1) -> IDLE.
- Reset values: all registers 0; div_in_vld_o=0; div_ready_o=0 while rst_i=1.
- div_ready_o = (state==IDLE) & ~flush_i.
- Accept: fu_valid_i & div_ready_o.
  - Register operands, op_i, trans_id_i and word_q.
  - Go to ISSUE.
  - Accept with fu_valid_i low or in a non-IDLE state is ignored.
- Operand extension at accept, word_i=1:
  - op_i[0]=1 (signed): sign-extend bits [31:0].
  - op_i[0]=0 (unsigned): zero-extend bits [31:0].
- word_i=0: operands pass unchanged.
- ISSUE:
  - div_in_vld_o=1, combinational from state, first asserted the cycle after accept.
  - div_in_vld_o & div_in_rdy_i -> BUSY.
  - div_in_rdy_i low -> hold ISSUE with operands stable.
- BUSY:
  - div_out_rdy_o = ~mul_valid_i. The multiplier always wins the writeback port.
  - div_out_vld_i & ~mul_valid_i -> divider writeback this cycle, next state IDLE.
  - If mul_valid_i is high, the divider result is held and retried the next cycle.
- div_out_rdy_o=0 outside BUSY.
- Writeback mux:
  - mul_valid_i -> valid_o=1, result_o=mul_result_i, trans_id_o=mul_trans_id_i.
  - Else BUSY & div_out_vld_i & ~flush_i -> valid_o=1, trans_id_o=div_id_i.
    - result_o = word_q ? sign-extend(div_res_i[31:0]) : div_res_i.
    - The sign extension also applies to unsigned W ops.
  - Else valid_o=0, result_o=0, trans_id_o=0.
- Writeback path is purely combinational. No backpressure from writeback.
- Latency:
  - accept at cycle N -> div_in_vld_o at N+1 -> writeback in the cycle the divider asserts out_vld, unless collided.
  - Next op can be accepted the cycle after divider writeback.
  - No accept in the same cycle as completion.
- flush_i:
  - Next state IDLE from any state; word_q cleared; div_in_vld_o forced 0 in the flush cycle.
  - Divider writeback suppressed in the flush cycle.
  - Multiplier writeback unaffected; the multiplier pipeline handles its own flush.
- Flush coinciding with fu_valid_i: no accept.
- Reset mid-operation: immediate return to IDLE; no writeback for the lost op.

Test Plan:
- DIVW (op=1, word=1): a=0x0000_0000_FFFF_FFF9 (-7), b=2 -> div_op_a_o=0xFFFF_FFFF_FFFF_FFF9; divider returns 0x...FFFD -> result_o=0xFFFF_FFFF_FFFF_FFFD; trans_id_o matches; valid_o for exactly one cycle.
- DIVUW (op=0, word=1): a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> div_op_a_o=0x0000_0000_FFFF_FFFF; result 0xFFFF_FFFF -> result_o=0xFFFF_FFFF_FFFF_FFFF.
- Collision: mul_valid_i=1 (id 5, data 0x1234) in the same cycle as div_out_vld_i (id 2).
  - Required: mul writes back that cycle; div_out_rdy_o=0.
  - Div (id 2) writes back the next cycle.
- Back-to-back 64-bit REM ops:
  - div_ready_o low from accept until divider writeback, high the following cycle.
  - A second fu_valid_i during BUSY is not accepted.
- Flush in BUSY: state returns to IDLE; no valid_o for the divide id; div_ready_o=1 the next cycle; a new DIV 100/7 then returns 14.
- Assert rst_i during ISSUE: div_in_vld_o=0 asynchronously; after release, IDLE with div_ready_o=1.
